freq_window_monitor: RTL
========================

Name: freq_window_monitor

Overview:
- Downstream consumer of the frequency counter's 32-bit `freq` measurement, in the same `ref_clk` domain.
- Qualifies each new measurement against a programmable [lo_thr, hi_thr] window.
- A debounced lock/loss FSM tracks window status; raises a sticky alarm on loss.
- Keeps running min/max/sample-count statistics for software readback.

Parameters:
- W, 32, width of freq, thresholds, fmin, fmax.
- LOCK_CNT, 4, consecutive in-range samples needed to declare lock (1..255).
- LOSS_CNT, 2, consecutive out-of-range samples while locked needed to declare loss (1..255).

Ports:
- ref_clk  in  1  sole clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- en  in  1  block enable; samples ignored when low.
- freq_valid  in  1  one-cycle strobe: freq holds a new measurement.
- freq  in  W  measured frequency in Hz.
- lo_thr  in  W  inclusive lower bound.
- hi_thr  in  W  inclusive upper bound.
- clr  in  1  synchronous clear of alarm and statistics.
- in_range  out  1  window result of the last accepted sample.
- locked  out  1  high only in LOCKED state.
- alarm  out  1  sticky; set on entry to LOSS.
- fmin  out  W  smallest accepted sample since reset/clr.
- fmax  out  W  largest accepted sample since reset/clr.
- sample_cnt  out  16  accepted samples since reset/clr, saturating.

Behaviour:
- Reset (async, rst_=0):
  - FSM=UNLOCKED; good_cnt=bad_cnt=0.
  - in_range=0, locked=0, alarm=0.
  - fmin=all ones, fmax=0, sample_cnt=0.
- Accept = en & freq_valid. All outputs are registered and update on the edge that samples accept (1-cycle latency). No accept means all state holds.
- Window test: hit = (freq >= lo_thr) & (freq <= hi_thr), unsigned. If lo_thr > hi_thr, every sample misses. Thresholds are sampled at accept time only.
- Statistics on accept:
  - fmin = min(fmin, freq); fmax = max(fmax, freq).
  - sample_cnt += 1, saturating at 0xFFFF.
- FSM, evaluated on accept only:
  - UNLOCKED: hit -> good_cnt=1, and go to LOCKED if LOCK_CNT==1, else ACQUIRE. Miss -> stay.
  - ACQUIRE: hit -> good_cnt+1; reaching LOCK_CNT -> LOCKED, good_cnt=0. Miss -> UNLOCKED, good_cnt=0.
  - LOCKED: hit -> bad_cnt=0. Miss -> bad_cnt+1; reaching LOSS_CNT -> LOSS, alarm=1, bad_cnt=0.
  - LOSS: hit -> good_cnt=1, go to ACQUIRE (or LOCKED if LOCK_CNT==1). Miss -> stay.
- alarm stays set until clr, regardless of later relock.
- clr: alarm=0, fmin=all ones, fmax=0, sample_cnt=0. FSM and counters are unaffected.
- clr and accept in the same cycle:
  - Statistics reflect only that sample: fmin=fmax=freq, sample_cnt=1.
  - alarm=1 only if that sample causes entry to LOSS, else 0.
- en low mid-sequence freezes the FSM and counters. Debounce resumes where it left off when en returns.
- Async reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro FREQ_MON_AVG_EN.
- Defined:
  - The window test uses the 4-sample moving average instead of raw freq. avg = (sum of last 4 accepted samples) >> 2, sum width W+2, truncating.
  - Adds output freq_avg[W-1:0].
  - The history buffer clears on reset and on clr.
  - Until 4 samples are held, hit is forced 0 and the FSM does not leave UNLOCKED/LOSS.
  - Statistics always use raw freq.
- Undefined: raw freq is compared, freq_avg is absent, and no history registers exist.

Test Plan:
- Settings for all: LOCK_CNT=4, LOSS_CNT=2, lo_thr=9_900_000, hi_thr=10_100_000.
- Lock: after reset, four accepted samples of 10_000_000 -> locked rises on the 4th sample's accept edge; in_range=1; sample_cnt=4.
- Acquire abort: samples 10_000_000 x3, 12_000_000, then 10_000_000 x4 -> locked only after the final 4th in-range sample; alarm=0.
- Loss and sticky alarm:
  - From LOCKED, samples 9_800_000, 10_000_000, 9_800_000, 9_800_000 -> stays locked after the first miss (bad_cnt reset by the hit); locked=0 and alarm=1 after the last two misses.
  - Four more 10_000_000 -> locked=1 and alarm still 1.
- Clear collision: clr and accept of 10_050_000 in the same cycle -> fmin=fmax=10_050_000, sample_cnt=1, alarm=0, FSM state unchanged apart from that sample's own transition.
- Edges and gating:
  - freq=9_900_000 and 10_100_000 -> in_range=1; 10_100_001 -> in_range=0.
  - lo_thr=11_000_000 > hi_thr -> all misses.
  - freq_valid pulses with en=0 -> no output change.
  - 70_000 accepts -> sample_cnt=0xFFFF.
- With FREQ_MON_AVG_EN: samples 10_000_000 x3 then 10_400_000 -> locked stays 0 through the 3rd sample; freq_avg=10_100_000 and in_range=1 on the 4th.

Source files
------------

// File: rtl/freq_window_monitor.sv
// freq_window_monitor
//   Qualifies each accepted frequency measurement against an inclusive
//   [lo_thr, hi_thr] window. A debounced lock/loss FSM tracks window status
//   and raises a sticky alarm on loss. Running min/max/sample-count
//   statistics are kept for software readback.
//
//   Optional build macro FREQ_MON_AVG_EN: the window test uses the 4-sample
//   moving average of accepted samples and the freq_avg output is added.
//
// Ports
//   ref_clk      sole clock, rising edge
//   rst_         asynchronous active-low reset
//   en           block enable; samples ignored when low
//   freq_valid   one-cycle strobe, freq holds a new measurement
//   freq         measured frequency (Hz)
//   lo_thr       inclusive lower bound
//   hi_thr       inclusive upper bound
//   clr          synchronous clear of alarm and statistics
//   in_range     window result of the last accepted sample
//   locked       high only in LOCKED state
//   alarm        sticky, set on entry to LOSS
//   fmin, fmax   smallest / largest accepted sample since reset/clr
//   sample_cnt   accepted samples since reset/clr, saturating
//   freq_avg     moving average of last 4 samples (FREQ_MON_AVG_EN only)
module freq_window_monitor #(
  parameter int W        = 32,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2
) (
  input  logic         ref_clk,
  input  logic         rst_,
  input  logic         en,
  input  logic         freq_valid,
  input  logic [W-1:0] freq,
  input  logic [W-1:0] lo_thr,
  input  logic [W-1:0] hi_thr,
  input  logic         clr,
  output logic         in_range,
  output logic         locked,
  output logic         alarm,
  output logic [W-1:0] fmin,
  output logic [W-1:0] fmax,
  output logic [15:0]  sample_cnt
`ifdef FREQ_MON_AVG_EN
  ,
  output logic [W-1:0] freq_avg
`endif
);

  localparam logic [7:0] LOCK_C = LOCK_CNT[7:0];
  localparam logic [7:0] LOSS_C = LOSS_CNT[7:0];

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_LOCKED   = 2'd2,
    S_LOSS     = 2'd3
  } state_t;

  function automatic logic in_window(input logic [W-1:0] v,
                                     input logic [W-1:0] lo,
                                     input logic [W-1:0] hi);
    // An inverted window (lo > hi) can never satisfy both bounds.
    return (v >= lo) && (v <= hi);
  endfunction

  logic         accept;
  logic         hit;

  state_t       state_q;
  logic [7:0]   good_cnt_q;
  logic [7:0]   bad_cnt_q;
  logic         in_range_q;
  logic         locked_q;
  logic         alarm_q;

  logic [W-1:0] fmin_q, fmin_d;
  logic [W-1:0] fmax_q, fmax_d;
  logic [15:0]  cnt_q, cnt_d;

  assign accept = en & freq_valid;

`ifdef FREQ_MON_AVG_EN
  // Three previous accepted samples; the current sample completes the four.
  logic [W-1:0] hist0_q, hist1_q, hist2_q;
  logic [1:0]   hist_cnt_q;
  logic [W-1:0] h0_eff, h1_eff, h2_eff;
  logic [W+1:0] sum;
  logic [W-1:0] avg;
  logic [W-1:0] freq_avg_q;

  always_comb begin
    // A same-cycle clr empties the history before this sample joins it.
    h0_eff = clr ? '0 : hist0_q;
    h1_eff = clr ? '0 : hist1_q;
    h2_eff = clr ? '0 : hist2_q;
    sum    = {2'b00, freq} + {2'b00, h0_eff} + {2'b00, h1_eff} + {2'b00, h2_eff};
    avg    = W'(sum >> 2);
    hit    = !clr && (hist_cnt_q == 2'd3) && in_window(avg, lo_thr, hi_thr);
  end

  always_ff @(posedge ref_clk or negedge rst_) begin
    if (!rst_) begin
      hist0_q    <= '0;
      hist1_q    <= '0;
      hist2_q    <= '0;
      hist_cnt_q <= '0;
      freq_avg_q <= '0;
    end else if (accept) begin
      hist0_q    <= freq;
      hist1_q    <= h0_eff;
      hist2_q    <= h1_eff;
      hist_cnt_q <= clr ? 2'd1 : ((hist_cnt_q == 2'd3) ? 2'd3 : hist_cnt_q + 2'd1);
      freq_avg_q <= avg;
    end else if (clr) begin
      hist0_q    <= '0;
      hist1_q    <= '0;
      hist2_q    <= '0;
      hist_cnt_q <= '0;
      freq_avg_q <= '0;
    end
  end

  assign freq_avg = freq_avg_q;
`else
  assign hit = in_window(freq, lo_thr, hi_thr);
`endif

  // Lock/loss FSM with registered status outputs.
  always_ff @(posedge ref_clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= S_UNLOCKED;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      in_range_q <= 1'b0;
      locked_q   <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      if (clr) alarm_q <= 1'b0;
      if (accept) begin
        in_range_q <= hit;
        case (state_q)
          S_UNLOCKED, S_LOSS: begin
            if (hit) begin
              if (LOCK_C == 8'd1) begin
                state_q    <= S_LOCKED;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
                locked_q   <= 1'b1;
              end else begin
                state_q    <= S_ACQUIRE;
                good_cnt_q <= 8'd1;
              end
            end
          end
          S_ACQUIRE: begin
            if (hit) begin
              if (good_cnt_q + 8'd1 == LOCK_C) begin
                state_q    <= S_LOCKED;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
                locked_q   <= 1'b1;
              end else begin
                good_cnt_q <= good_cnt_q + 8'd1;
              end
            end else begin
              state_q    <= S_UNLOCKED;
              good_cnt_q <= '0;
            end
          end
          S_LOCKED: begin
            if (hit) begin
              bad_cnt_q <= '0;
            end else if (bad_cnt_q + 8'd1 == LOSS_C) begin
              state_q   <= S_LOSS;
              bad_cnt_q <= '0;
              locked_q  <= 1'b0;
              // Overrides a same-cycle clr: the loss event is newer.
              alarm_q   <= 1'b1;
            end else begin
              bad_cnt_q <= bad_cnt_q + 8'd1;
            end
          end
          default: state_q <= S_UNLOCKED;
        endcase
      end
    end
  end

  // Statistics: a same-cycle clr restarts from the cleared values so the
  // result reflects only the current sample.
  always_comb begin
    fmin_d = clr ? '1 : fmin_q;
    fmax_d = clr ? '0 : fmax_q;
    cnt_d  = clr ? '0 : cnt_q;
    if (accept) begin
      if (freq < fmin_d) fmin_d = freq;
      if (freq > fmax_d) fmax_d = freq;
      if (cnt_d != 16'hFFFF) cnt_d = cnt_d + 16'd1;
    end
  end

  always_ff @(posedge ref_clk or negedge rst_) begin
    if (!rst_) begin
      fmin_q <= '1;
      fmax_q <= '0;
      cnt_q  <= '0;
    end else begin
      fmin_q <= fmin_d;
      fmax_q <= fmax_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_range   = in_range_q;
  assign locked     = locked_q;
  assign alarm      = alarm_q;
  assign fmin       = fmin_q;
  assign fmax       = fmax_q;
  assign sample_cnt = cnt_q;

endmodule
